// File: rtl/alu_stage_pkg.sv
// Shared types and constants for the ALU result stage.
package alu_stage_pkg;

  localparam int unsigned DefDataWidth    = 16;
  localparam int unsigned DefRegAddrWidth = 3;

  // Condition-code reset value {n, z, p, co}: the machine starts out "zero".
  localparam logic [3:0] CcReset = 4'b0100;

  // Skid buffer occupancy.
  typedef enum logic [1:0] {
    BufEmpty = 2'd0,
    BufOne   = 2'd1,
    BufFull  = 2'd2
  } buf_state_e;

  // One buffered writeback entry at the default widths.
  typedef struct packed {
    logic [DefDataWidth-1:0]    result;
    logic                       wr_en;
    logic [DefRegAddrWidth-1:0] dest;
  } entry_t;

endpackage

// File: rtl/result_skid_buf.sv
// Two-entry FIFO-ordered skid buffer feeding the register-file writeback port.
// in_ready depends on registered occupancy only, so there is no in/out ready path.
module result_skid_buf
  import alu_stage_pkg::*;
#(
  parameter type ent_t = alu_stage_pkg::entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  ent_t in_entry,
  output logic out_valid,
  input  logic out_ready,
  output ent_t out_entry
);

  buf_state_e state_q, state_d;
  ent_t       head_q, head_d;
  ent_t       tail_q, tail_d;
  logic       push, pop;

  // Occupancy register and entry storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BufEmpty;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Next occupancy and entry movement; head is always entry 0.
  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    in_ready  = (state_q != BufFull);
    out_valid = (state_q != BufEmpty);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    unique case (state_q)
      BufEmpty: begin
        if (push) begin
          head_d  = in_entry;
          state_d = BufOne;
        end
      end
      BufOne: begin
        if (push && pop) begin
          head_d = in_entry;
        end else if (push) begin
          tail_d  = in_entry;
          state_d = BufFull;
        end else if (pop) begin
          state_d = BufEmpty;
        end
      end
      BufFull: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = BufOne;
        end
      end
      default: state_d = BufEmpty;
    endcase
  end

  assign out_entry = head_q;

endmodule

// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: skid-buffers ALU results, owns the condition
// codes and evaluates branch conditions.
// Optional feature macro: ALU_CARRY_CC_EN (adds the cc_co carry register).
module alu_result_stage
  import alu_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DefDataWidth,
  parameter int unsigned REG_ADDR_WIDTH = DefRegAddrWidth
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_result,
  input  logic                      in_n,
  input  logic                      in_z,
  input  logic                      in_p,
  input  logic                      in_co,
  input  logic                      in_set_cc,
  input  logic                      in_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] in_dest,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_result,
  output logic                      out_wr_en,
  output logic [REG_ADDR_WIDTH-1:0] out_dest,
  output logic                      cc_n,
  output logic                      cc_z,
  output logic                      cc_p,
  output logic                      cc_co,
  input  logic [2:0]                br_mask,
  output logic                      br_taken
);

  // Entry layout at this instance's widths; matches entry_t at the defaults.
  typedef struct packed {
    logic [DATA_WIDTH-1:0]     result;
    logic                      wr_en;
    logic [REG_ADDR_WIDTH-1:0] dest;
  } stage_entry_t;

  stage_entry_t in_entry, out_entry;
  logic         cc_load;
  logic [2:0]   nzp_q;

  assign in_entry = '{result: in_result, wr_en: in_wr_en, dest: in_dest};

  result_skid_buf #(
    .ent_t (stage_entry_t)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_entry  (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_entry (out_entry)
  );

  assign out_result = out_entry.result;
  assign out_wr_en  = out_entry.wr_en;
  assign out_dest   = out_entry.dest;

  // Only accepted results may touch the condition codes.
  assign cc_load = in_valid && in_ready && in_set_cc;

  // N/Z/P condition-code register.
  always_ff @(posedge clk) begin
    if (rst) begin
      nzp_q <= CcReset[3:1];
    end else if (cc_load) begin
      nzp_q <= {in_n, in_z, in_p};
    end
  end

`ifdef ALU_CARRY_CC_EN
  logic co_q;

  // Carry condition-code register.
  always_ff @(posedge clk) begin
    if (rst) begin
      co_q <= CcReset[0];
    end else if (cc_load) begin
      co_q <= in_co;
    end
  end

  assign cc_co = co_q;
`else
  logic unused_in_co;
  assign unused_in_co = in_co;
  assign cc_co        = 1'b0;
`endif

  assign {cc_n, cc_z, cc_p} = nzp_q;
  assign br_taken           = |(br_mask & nzp_q);

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] in_result;
  logic        in_n, in_z, in_p, in_co, in_set_cc, in_wr_en;
  logic [2:0]  in_dest;
  logic        out_valid, out_ready;
  logic [15:0] out_result;
  logic        out_wr_en;
  logic [2:0]  out_dest;
  logic        cc_n, cc_z, cc_p, cc_co;
  logic [2:0]  br_mask;
  logic        br_taken;

  int vectors = 0;
  int errors  = 0;
  logic exp_co;

  always #5 clk = ~clk;

  alu_result_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_n       (in_n),
    .in_z       (in_z),
    .in_p       (in_p),
    .in_co      (in_co),
    .in_set_cc  (in_set_cc),
    .in_wr_en   (in_wr_en),
    .in_dest    (in_dest),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_wr_en  (out_wr_en),
    .out_dest   (out_dest),
    .cc_n       (cc_n),
    .cc_z       (cc_z),
    .cc_p       (cc_p),
    .cc_co      (cc_co),
    .br_mask    (br_mask),
    .br_taken   (br_taken)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] r, input logic [3:0] nzpc,
                       input logic sc, input logic we, input logic [2:0] d);
    in_valid  = v;
    in_result = r;
    {in_n, in_z, in_p, in_co} = nzpc;
    in_set_cc = sc;
    in_wr_en  = we;
    in_dest   = d;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    br_mask = 3'b000;
    drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 3'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // Reset / idle
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_dest", out_dest, 0);
    check("rst_out_wr_en", out_wr_en, 0);
    check("rst_cc", {cc_n, cc_z, cc_p}, 3'b010);
    check("rst_cc_co", cc_co, 0);
    br_mask = 3'b010; #1;
    check("rst_br_z", br_taken, 1);
    br_mask = 3'b000; #1;
    check("br_mask_zero", br_taken, 0);

    // Single push with cc update, one-cycle latency
    out_ready = 1'b1;
    drive(1'b1, 16'h8001, 4'b1000, 1'b1, 1'b1, 3'd3);
    step();
    drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 3'd0);
    check("push1_valid", out_valid, 1);
    check("push1_result", out_result, 16'h8001);
    check("push1_dest", out_dest, 3);
    check("push1_wr_en", out_wr_en, 1);
    check("push1_cc", {cc_n, cc_z, cc_p}, 3'b100);
    br_mask = 3'b100; #1;
    check("br_n", br_taken, 1);
    br_mask = 3'b011; #1;
    check("br_zp_not", br_taken, 0);
    br_mask = 3'b111; #1;
    check("br_all", br_taken, 1);
    step();
    check("push1_drained", out_valid, 0);

    // Fill to FULL with writeback stalled, then drain in order
    out_ready = 1'b0;
    drive(1'b1, 16'h0001, 4'b0010, 1'b0, 1'b1, 3'd1);
    step();
    drive(1'b1, 16'h0002, 4'b0010, 1'b0, 1'b1, 3'd2);
    step();
    check("full_in_ready", in_ready, 0);
    check("full_head", out_result, 16'h0001);
    // Ignored push, including its set_cc
    drive(1'b1, 16'h0003, 4'b0011, 1'b1, 1'b1, 3'd4);
    step();
    check("full_hold_head", out_result, 16'h0001);
    check("full_hold_dest", out_dest, 1);
    check("full_ignored_cc", {cc_n, cc_z, cc_p}, 3'b100);
    drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 3'd0);
    out_ready = 1'b1;
    step();
    check("drain_second", out_result, 16'h0002);
    check("drain_valid", out_valid, 1);
    check("drain_in_ready", in_ready, 1);
    step();
    check("drain_empty", out_valid, 0);

    // ONE with simultaneous push and pop
    out_ready = 1'b0;
    drive(1'b1, 16'h0055, 4'h0, 1'b0, 1'b0, 3'd5);
    step();
    out_ready = 1'b1;
    drive(1'b1, 16'h00AA, 4'h0, 1'b0, 1'b1, 3'd6);
    step();
    drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 3'd0);
    check("pp_head", out_result, 16'h00AA);
    check("pp_dest", out_dest, 6);
    check("pp_in_ready", in_ready, 1);
    step();
    check("pp_stayed_one", out_valid, 0);

    // cc hold on set_cc = 0, and carry behaviour
    drive(1'b1, 16'h0010, 4'b0010, 1'b1, 1'b0, 3'd0);
    step();
    check("cc_p", {cc_n, cc_z, cc_p}, 3'b001);
    drive(1'b1, 16'h0011, 4'b1101, 1'b0, 1'b0, 3'd0);
    step();
    check("cc_hold_nzp", {cc_n, cc_z, cc_p}, 3'b001);
    check("cc_hold_co", cc_co, 0);
    drive(1'b1, 16'h0012, 4'b0111, 1'b1, 1'b0, 3'd0);
    step();
    drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 3'd0);
`ifdef ALU_CARRY_CC_EN
    exp_co = 1'b1;
`else
    exp_co = 1'b0;
`endif
    check("cc_multi_hot", {cc_n, cc_z, cc_p}, 3'b011);
    check("cc_co_load", cc_co, exp_co);
    step();

    // Reset while FULL, with a push offered on the reset edge
    out_ready = 1'b0;
    drive(1'b1, 16'h0100, 4'b1000, 1'b1, 1'b1, 3'd7);
    step();
    drive(1'b1, 16'h0200, 4'b1000, 1'b1, 1'b1, 3'd7);
    step();
    check("pre_rst_full", in_ready, 0);
    check("pre_rst_cc", {cc_n, cc_z, cc_p}, 3'b100);
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 3'd0);
    out_ready = 1'b0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_cc", {cc_n, cc_z, cc_p}, 3'b010);
    check("mid_rst_co", cc_co, 0);
    check("mid_rst_result", out_result, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
